// File: rtl/interboard_pkg.sv
// Shared definitions for the two-board Bingo link (receiver and transmitter):
// message types, beat field positions and the receiver FSM encoding.
package interboard_pkg;

  localparam logic [2:0] MSG_START  = 3'd1;
  localparam logic [2:0] MSG_NUMBER = 3'd2;
  localparam logic [2:0] MSG_WIN    = 3'd3;
  localparam logic [2:0] MSG_RESET  = 3'd7;

  localparam int HDR_BIT  = 5;
  localparam int TYPE_MSB = 4;
  localparam int TYPE_LSB = 2;
  localparam int PAR_BIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_DRAIN = 2'd2
  } rx_state_e;

  // Even parity over {msg_type, number}; the sender puts this in header bit 0.
  function automatic logic msg_parity(input logic [2:0] msg_type, input logic [4:0] number);
    return ^{msg_type, number};
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous control bit (Request/Ack).
// STAGES must be at least 2.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/interboard_receiver.sv
// Receive end of the inter-board link: four-phase Request/Ack handshake and
// two-beat frame reassembly. Optional header parity check under INTER_PARITY_EN.
//
//   state    | meaning
//   ST_IDLE  | Ack low, waiting for Request (may be mid-frame awaiting data beat)
//   ST_ACK   | beat latched, Ack high, waiting for Request to fall
//   ST_DRAIN | beat abandoned on timeout, Ack low, waiting for Request to fall
module interboard_receiver
  import interboard_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       interboard_en,
  output logic [2:0] interboard_msg_type,
  output logic [4:0] interboard_number,
  output logic       interboard_rst,
  output logic       frame_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rx_state_e        state_q, state_d;
  logic             expect_data_q, expect_data_d;
  logic [5:0]       beat_q, beat_d;
  logic [2:0]       hdr_type_q, hdr_type_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             en_q, en_d;
  logic             rstp_q, rstp_d;
  logic             err_q, err_d;
  logic [2:0]       type_q, type_d;
  logic [4:0]       num_q, num_d;
  logic             req_s;
  logic             timed_out;
  logic             parity_ok;
`ifdef INTER_PARITY_EN
  logic             hdr_par_q, hdr_par_d;
`endif

  sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (Request_in),
    .q_o (req_s)
  );

  assign timed_out = (cnt_q == CNT_LAST);

`ifdef INTER_PARITY_EN
  assign parity_ok = (hdr_par_q == msg_parity(hdr_type_q, beat_q[4:0]));
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    expect_data_d = expect_data_q;
    beat_d        = beat_q;
    hdr_type_d    = hdr_type_q;
    cnt_d         = cnt_q;
    ack_d         = ack_q;
    en_d          = 1'b0;
    rstp_d        = 1'b0;
    err_d         = 1'b0;
    type_d        = type_q;
    num_d         = num_q;
`ifdef INTER_PARITY_EN
    hdr_par_d     = hdr_par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          beat_d  = inter_data_in;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else if (expect_data_q) begin
          if (timed_out) begin
            err_d         = 1'b1;
            expect_data_d = 1'b0;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
          if (!expect_data_q) begin
            if (beat_q[HDR_BIT]) begin
              hdr_type_d    = beat_q[TYPE_MSB:TYPE_LSB];
              expect_data_d = 1'b1;
`ifdef INTER_PARITY_EN
              hdr_par_d     = beat_q[PAR_BIT];
`endif
            end else begin
              err_d = 1'b1;
            end
          end else if (!beat_q[HDR_BIT]) begin
            expect_data_d = 1'b0;
            if (parity_ok) begin
              type_d = hdr_type_q;
              num_d  = beat_q[4:0];
              en_d   = 1'b1;
              rstp_d = (hdr_type_q == MSG_RESET);
            end else begin
              err_d = 1'b1;
            end
          end else begin
            // A header where data was due: report it and resync on this header.
            err_d      = 1'b1;
            hdr_type_d = beat_q[TYPE_MSB:TYPE_LSB];
`ifdef INTER_PARITY_EN
            hdr_par_d  = beat_q[PAR_BIT];
`endif
          end
        end else if (timed_out) begin
          ack_d         = 1'b0;
          err_d         = 1'b1;
          expect_data_d = 1'b0;
          state_d       = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!req_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      expect_data_q <= 1'b0;
      beat_q        <= '0;
      hdr_type_q    <= '0;
      cnt_q         <= '0;
      ack_q         <= 1'b0;
      en_q          <= 1'b0;
      rstp_q        <= 1'b0;
      err_q         <= 1'b0;
      type_q        <= '0;
      num_q         <= '0;
`ifdef INTER_PARITY_EN
      hdr_par_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      expect_data_q <= expect_data_d;
      beat_q        <= beat_d;
      hdr_type_q    <= hdr_type_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      en_q          <= en_d;
      rstp_q        <= rstp_d;
      err_q         <= err_d;
      type_q        <= type_d;
      num_q         <= num_d;
`ifdef INTER_PARITY_EN
      hdr_par_q     <= hdr_par_d;
`endif
    end
  end

  assign Ack_out             = ack_q;
  assign interboard_en       = en_q;
  assign interboard_rst      = rstp_q;
  assign frame_err           = err_q;
  assign interboard_msg_type = type_q;
  assign interboard_number   = num_q;

endmodule

// File: tb/tb_interboard_receiver.sv
// Bench for interboard_receiver: directed four-phase frames, expected strobes
// queued by the stimulus and checked by an independent output monitor.
module tb_interboard_receiver;

  localparam int SYNC = 2;
  localparam int TMO  = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [5:0] data;
  logic       Ack_out, interboard_en, interboard_rst, frame_err;
  logic [2:0] interboard_msg_type;
  logic [4:0] interboard_number;

  interboard_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Request_in          (req),
    .inter_data_in       (data),
    .Ack_out             (Ack_out),
    .interboard_en       (interboard_en),
    .interboard_msg_type (interboard_msg_type),
    .interboard_number   (interboard_number),
    .interboard_rst      (interboard_rst),
    .frame_err           (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [2:0] t;
    logic [4:0] n;
    logic       r;
  } exp_t;

  exp_t       expq[$];
  exp_t       mon_e;
  int         tests = 0;
  int         fails = 0;
  logic [2:0] last_t = 3'd0;
  logic [4:0] last_n = 5'd0;

  function automatic logic [5:0] hdr(input logic [2:0] t, input logic [4:0] n, input logic bad);
    return {1'b1, t, 1'b0, (^{t, n}) ^ bad};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_msg(input logic [2:0] t, input logic [4:0] n);
    expq.push_back('{1'b0, t, n, (t == 3'd7)});
    last_t = t;
    last_n = n;
  endtask

  task automatic push_err();
    expq.push_back('{1'b1, last_t, last_n, 1'b0});
  endtask

  task automatic wait_ack(input logic lvl, input string name);
    int n = 0;
    while (Ack_out !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, Ack_out, lvl);
  endtask

  task automatic send_beat(input logic [5:0] d);
    int n = 0;
    @(negedge clk);
    data = d;
    req  = 1'b1;
    wait_ack(1'b1, "ack_rise");
    @(negedge clk);
    req = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (Ack_out && n < 200);
    check("ack_fall_latency", n, SYNC + 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [2:0] t, input logic [4:0] n);
    push_msg(t, n);
    send_beat(hdr(t, n, 1'b0));
    send_beat({1'b0, n});
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (interboard_en || frame_err || interboard_rst) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: en=%0d err=%0d rst=%0d with nothing expected",
                 interboard_en, frame_err, interboard_rst);
      end else begin
        mon_e = expq.pop_front();
        if (interboard_en !== !mon_e.is_err || frame_err !== mon_e.is_err ||
            interboard_rst !== mon_e.r || interboard_msg_type !== mon_e.t ||
            interboard_number !== mon_e.n) begin
          fails++;
          $display("FAIL strobe_check: got en=%0d err=%0d rst=%0d type=%0d num=%0d expected en=%0d err=%0d rst=%0d type=%0d num=%0d",
                   interboard_en, frame_err, interboard_rst, interboard_msg_type,
                   interboard_number, !mon_e.is_err, mon_e.is_err, mon_e.r, mon_e.t, mon_e.n);
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = 1'b0;
    data = 6'd0;
    repeat (4) @(negedge clk);
    check("reset_ack", Ack_out, 0);
    check("reset_en", interboard_en, 0);
    check("reset_err", frame_err, 0);
    check("reset_type", interboard_msg_type, 0);
    check("reset_num", interboard_number, 0);
    check("reset_rst", interboard_rst, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic NUMBER frame, then a RESET frame.
    push_msg(3'd2, 5'd13);
    send_beat(6'b1_010_00 | {5'd0, ^{3'd2, 5'd13}});
    send_beat(6'b0_01101);
    send_frame(3'd7, 5'd0);

    // Data beat while a header is expected.
    push_err();
    send_beat(6'b0_00101);
    send_frame(3'd3, 5'd24);

    // Header received, data beat never arrives.
    push_err();
    send_beat(hdr(3'd1, 5'd0, 1'b0));
    repeat (TMO + 10) @(negedge clk);
    send_frame(3'd1, 5'd5);

    // Request held high past the timeout.
    push_err();
    @(negedge clk);
    data = hdr(3'd3, 5'd0, 1'b0);
    req  = 1'b1;
    wait_ack(1'b1, "tmo_ack_rise");
    repeat (TMO + 5) @(negedge clk);
    check("tmo_ack_dropped", Ack_out, 0);
    repeat (5) @(negedge clk);
    check("tmo_ack_held_low", Ack_out, 0);
    req = 1'b0;
    repeat (6) @(negedge clk);
    check("tmo_drain_idle_ack", Ack_out, 0);
    send_frame(3'd2, 5'd1);

    // Reset during the ACK phase of a data beat.
    send_beat(hdr(3'd2, 5'd7, 1'b0));
    @(negedge clk);
    data = 6'b0_00111;
    req  = 1'b1;
    wait_ack(1'b1, "rst_ack_rise");
    rst = 1'b1;
    @(negedge clk);
    check("rst_ack_low", Ack_out, 0);
    check("rst_no_en", interboard_en, 0);
    check("rst_no_err", frame_err, 0);
    check("rst_type_cleared", interboard_msg_type, 0);
    rst    = 1'b0;
    req    = 1'b0;
    last_t = 3'd0;
    last_n = 5'd0;
    repeat (6) @(negedge clk);
    send_frame(3'd2, 5'd7);

    // Header followed by another header: error, then resync on the second.
    send_beat(hdr(3'd3, 5'd0, 1'b0));
    push_err();
    send_beat(hdr(3'd2, 5'd9, 1'b0));
    push_msg(3'd2, 5'd9);
    send_beat(6'b0_01001);

`ifdef INTER_PARITY_EN
    // Wrong parity: error strobe, outputs keep the previous message.
    push_err();
    send_beat(hdr(3'd2, 5'd13, 1'b1));
    send_beat(6'b0_01101);
    check("par_type_held", interboard_msg_type, 2);
    check("par_num_held", interboard_number, 9);
    send_frame(3'd1, 5'd3);
`endif

    repeat (10) @(negedge clk);
    check("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
